pin_pattern_gen: RTL

Parametrised board-level I/O exercise pattern generator for hardware bring-up. It drives a WIDTH-bit pin bus with one of four selectable deterministic patterns, advanced once per prescaler period. Patterns are a rule-30 cellular automaton, a walking one, a Gray-code count and a toggling checkerboard. Pause and single-step controls allow pin-by-pin probing, and a tick strobe marks each update so a logic analyser or a downstream checker can sample.

---
 rtl/pin_pattern_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/pin_pattern_gen.sv
// Bring-up pin exerciser: drives a WIDTH-bit bus with one of four deterministic
// patterns (rule-30 CA, walking one, Gray count, checkerboard) at a prescaled rate.
module pin_pattern_gen #(
    parameter int WIDTH     = 110,
    parameter int LOG2DELAY = 22,
    parameter int SEED_BIT  = 28
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             step,
    output logic [WIDTH-1:0] D,
    output logic             tick,
    output logic [1:0]       mode_active
);

    localparam logic [1:0] MODE_CA   = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_CHK  = 2'd3;

    logic [WIDTH-1:0]     d_q, d_d;
    logic [WIDTH-1:0]     gray_q, gray_d;
    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic [1:0]           mode_q, mode_d;

    logic [WIDTH-1:0] ca_next, walk_next, gray_inc;
    logic [WIDTH-1:0] ca_seed, walk_seed, chk_seed;
    logic             adv;

    // Rule 30 on a ring: neighbour indices wrap at both ends.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
        assign ca_next[gi]   = d_q[(gi + 1) % WIDTH] ^ (d_q[gi] | d_q[(gi + WIDTH - 1) % WIDTH]);
        assign ca_seed[gi]   = (gi == SEED_BIT);
        assign walk_seed[gi] = (gi == 0);
        assign chk_seed[gi]  = ((gi % 2) == 0);
    end

    assign walk_next = {d_q[WIDTH-2:0], d_q[WIDTH-1]};
    assign gray_inc  = gray_q + WIDTH'(1);
    assign adv       = (!pause && (presc_q == {LOG2DELAY{1'b1}})) || (pause && step);

    always_comb begin
        d_d     = d_q;
        gray_d  = gray_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        mode_d  = mode_q;
        if (mode != mode_q) begin
            // Mode switch wins over a coincident advance; that advance is lost.
            mode_d  = mode;
            presc_d = '0;
            gray_d  = '0;
            case (mode)
                MODE_CA:   d_d = ca_seed;
                MODE_WALK: d_d = walk_seed;
                MODE_GRAY: d_d = '0;
                default:   d_d = chk_seed;
            endcase
        end else begin
            if (!pause) begin
                presc_d = presc_q + LOG2DELAY'(1);
            end
            if (adv) begin
                tick_d = 1'b1;
                case (mode_q)
                    MODE_CA:   d_d = ca_next;
                    MODE_WALK: d_d = walk_next;
                    MODE_GRAY: begin
                        gray_d = gray_inc;
                        d_d    = gray_inc ^ (gray_inc >> 1);
                    end
                    MODE_CHK:  d_d = ~d_q;
                    default:   d_d = d_q;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            d_q     <= ca_seed;
            gray_q  <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_CA;
        end else begin
            d_q     <= d_d;
            gray_q  <= gray_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
        end
    end

    assign D           = d_q;
    assign tick        = tick_q;
    assign mode_active = mode_q;

endmodule
